// File: rtl/freq_dop_pkg.sv
// Shared definitions for the Doppler speed-pulse link: clock rate and
// the measuring FSM state encoding.
package freq_dop_pkg;

    localparam int unsigned CLK_HZ      = 25_000_000;
    // One second of stalled input at the system clock rate.
    localparam int unsigned TIMEOUT_DEF = CLK_HZ;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

endpackage

// File: rtl/freq_dop_meas_if.sv
// Speed-pulse meter bus: enable and pulse input towards the meter,
// measured period, update strobe and stall flag back from it.
interface freq_dop_meas_if #(
    parameter int unsigned CNT_W = 28
);
    logic             I_stat;
    logic             I_spd;
    logic [CNT_W-1:0] O_period;
    logic             O_valid;
    logic             O_timeout;

    modport master (
        output I_stat, I_spd,
        input  O_period, O_valid, O_timeout
    );

    modport slave (
        input  I_stat, I_spd,
        output O_period, O_valid, O_timeout
    );
endinterface

// File: rtl/freq_dop_meas_spd_edge_filt.sv
// Asynchronous pulse input conditioner: 2-FF synchronizer, glitch filter
// requiring FILT_LEN agreeing samples, and a one-cycle rising-edge pulse.
module spd_edge_filt #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    localparam int unsigned RUN_W = $clog2(FILT_LEN + 1);

    logic [1:0]       sync;
    logic             level;
    logic [RUN_W-1:0] run;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            run   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            rise <= 1'b0;
            // run counts consecutive synchronized samples that disagree with level
            if (sync[1] != level) begin
                if (run == RUN_W'(FILT_LEN - 1)) begin
                    level <= sync[1];
                    run   <= '0;
                    rise  <= sync[1];
                end else begin
                    run <= run + 1'b1;
                end
            end else begin
                run <= '0;
            end
        end
    end
endmodule

// File: rtl/freq_dop_meas.sv
// Doppler speed-pulse frequency meter: measures (optionally averaged)
// period of I_spd in I_clk cycles and flags a stalled input.
module freq_dop_meas
    import freq_dop_pkg::*;
#(
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned AVG_LOG2 = 0,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic            I_clk,
    input  logic            I_reset,
    freq_dop_meas_if.slave  bus
);
    localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
    localparam int unsigned K_W   = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [K_W-1:0]   K_LAST = K_W'((1 << AVG_LOG2) - 1);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, idle_q, idle_n, period_q, period_n;
    logic [ACC_W-1:0] acc_q, acc_n, sum;
    logic [K_W-1:0]   k_q, k_n;
    logic             valid_q, valid_n, tout_q, tout_n;
    logic             rise;

    spd_edge_filt #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk  (I_clk),
        .rst  (I_reset),
        .din  (bus.I_spd),
        .rise (rise)
    );

    assign sum = acc_q + ACC_W'(cnt_q);

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idle_q   <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            idle_q   <= idle_n;
            acc_q    <= acc_n;
            k_q      <= k_n;
            period_q <= period_n;
            valid_q  <= valid_n;
            tout_q   <= tout_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        idle_n   = idle_q;
        acc_n    = acc_q;
        k_n      = k_q;
        period_n = period_q;
        valid_n  = 1'b0;
        tout_n   = tout_q;
        if (!bus.I_stat) begin
            state_n = IDLE;
            cnt_n   = '0;
            idle_n  = '0;
            acc_n   = '0;
            k_n     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n = ARM;
                    idle_n  = CNT_W'(1);
                end
                ARM: begin
                    if (rise) begin
                        state_n = MEAS;
                        cnt_n   = CNT_W'(1);
                        idle_n  = '0;
                        acc_n   = '0;
                        k_n     = '0;
                    end else begin
                        idle_n = (idle_q == '1) ? idle_q : idle_q + 1'b1;
                        // an already-flagged stall is not reported again
                        if (idle_q == TMO && !tout_q) begin
                            period_n = '0;
                            tout_n   = 1'b1;
                            valid_n  = 1'b1;
                        end
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt_n = CNT_W'(1);
                        if (k_q == K_LAST) begin
                            period_n = CNT_W'(sum >> AVG_LOG2);
                            valid_n  = 1'b1;
                            tout_n   = 1'b0;
                            acc_n    = '0;
                            k_n      = '0;
                        end else begin
                            acc_n = sum;
                            k_n   = k_q + 1'b1;
                        end
                    end else if (cnt_q == TMO) begin
                        state_n  = ARM;
                        period_n = '0;
                        tout_n   = 1'b1;
                        valid_n  = 1'b1;
                        cnt_n    = '0;
                        acc_n    = '0;
                        k_n      = '0;
                        idle_n   = CNT_W'(1);
                    end else begin
                        cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.O_period  = period_q;
    assign bus.O_valid   = valid_q;
    assign bus.O_timeout = tout_q;
endmodule

// File: tb/tb_freq_dop_meas.sv
// Scoreboard bench for freq_dop_meas: two instances (plain and 4-period
// averaging), directed pulse trains with hand-computed periods.
module tb_freq_dop_meas;

    typedef struct {
        logic [27:0] period;
        logic        timeout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #20 clk = ~clk;

    freq_dop_meas_if #(.CNT_W(28)) b0 ();
    freq_dop_meas_if #(.CNT_W(28)) b1 ();

    freq_dop_meas #(.CNT_W(28), .FILT_LEN(3), .AVG_LOG2(0), .TIMEOUT(1000)) dut0 (
        .I_clk(clk), .I_reset(rst), .bus(b0));
    freq_dop_meas #(.CNT_W(28), .FILT_LEN(3), .AVG_LOG2(2), .TIMEOUT(1000)) dut1 (
        .I_clk(clk), .I_reset(rst), .bus(b1));

    always @(negedge clk) begin
        if (b0.O_valid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_valid: got period=%0d timeout=%0b, required no strobe",
                         b0.O_period, b0.O_timeout);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (b0.O_period !== e.period || b0.O_timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL dut0_result: got period=%0d timeout=%0b, required period=%0d timeout=%0b",
                             b0.O_period, b0.O_timeout, e.period, e.timeout);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b1.O_valid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_valid: got period=%0d timeout=%0b, required no strobe",
                         b1.O_period, b1.O_timeout);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (b1.O_period !== e.period || b1.O_timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL dut1_result: got period=%0d timeout=%0b, required period=%0d timeout=%0b",
                             b1.O_period, b1.O_timeout, e.period, e.timeout);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push(input int which, input int p, input logic t);
        exp_t e;
        e.period  = 28'(p);
        e.timeout = t;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic hold(input int which, input logic v, input int n);
        if (which == 0) b0.I_spd = v;
        else            b1.I_spd = v;
        repeat (n) @(negedge clk);
    endtask

    // rising edge now, next rising edge (if any) exactly 'period' cycles later
    task automatic pulse(input int which, input int period, input int high);
        hold(which, 1'b1, high);
        hold(which, 1'b0, period - high);
    endtask

    initial begin
        int p1[9] = '{10, 12, 14, 16, 10, 10, 10, 11, 10};
        b0.I_stat = 1'b0; b0.I_spd = 1'b0;
        b1.I_stat = 1'b0; b1.I_spd = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        b0.I_spd = 1'b1;
        @(negedge clk);
        b0.I_spd = 1'b0;
        rst = 1'b0;
        chk("reset_period", 32'(b0.O_period), 0);
        chk("reset_valid", 32'(b0.O_valid), 0);
        chk("reset_timeout", 32'(b0.O_timeout), 0);
        chk("reset_period_avg", 32'(b1.O_period), 0);

        // averaging: 10,12,14,16 -> 13; 10,10,10,11 -> 41/4 truncated to 10
        b1.I_stat = 1'b1;
        repeat (5) @(negedge clk);
        push(1, 13, 1'b0);
        push(1, 10, 1'b0);
        foreach (p1[i]) pulse(1, p1[i], 5);
        repeat (10) @(negedge clk);
        b1.I_stat = 1'b0;
        repeat (5) @(negedge clk);

        // plain 20-cycle wave, then stall -> single timeout
        b0.I_stat = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) push(0, 20, 1'b0);
        push(0, 0, 1'b1);
        for (int i = 0; i < 5; i++) pulse(0, 20, 10);
        hold(0, 1'b0, 2200);
        chk("stall_period", 32'(b0.O_period), 0);
        chk("stall_timeout", 32'(b0.O_timeout), 1);

        // resume at 50 cycles; glitches of 1 and 2 cycles ignored, 3-cycle pulse accepted
        push(0, 50, 1'b0);
        push(0, 50, 1'b0);
        push(0, 73, 1'b0);
        push(0, 40, 1'b0);
        for (int i = 0; i < 3; i++) pulse(0, 50, 25);
        chk("resume_timeout", 32'(b0.O_timeout), 0);
        hold(0, 1'b1, 1);
        hold(0, 1'b0, 10);
        hold(0, 1'b1, 2);
        hold(0, 1'b0, 10);
        pulse(0, 40, 3);

        // enable dropped mid-period: partial discarded, result held
        hold(0, 1'b1, 20);
        hold(0, 1'b0, 10);
        b0.I_stat = 1'b0;
        hold(0, 1'b0, 10);
        chk("held_period", 32'(b0.O_period), 40);
        chk("held_timeout", 32'(b0.O_timeout), 0);
        b0.I_stat = 1'b1;
        hold(0, 1'b0, 5);
        push(0, 30, 1'b0);
        push(0, 30, 1'b0);
        for (int i = 0; i < 3; i++) pulse(0, 30, 15);
        chk("after_reenable_period", 32'(b0.O_period), 30);

        // one-cycle reset mid-measurement
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_period", 32'(b0.O_period), 0);
        chk("midreset_valid", 32'(b0.O_valid), 0);
        chk("midreset_timeout", 32'(b0.O_timeout), 0);

        // re-arm; period equal to TIMEOUT is captured, one cycle longer times out
        hold(0, 1'b0, 5);
        push(0, 60, 1'b0);
        push(0, 1000, 1'b0);
        push(0, 0, 1'b1);
        push(0, 20, 1'b0);
        pulse(0, 60, 30);
        pulse(0, 1000, 30);
        pulse(0, 1001, 30);
        pulse(0, 20, 10);
        pulse(0, 20, 10);
        hold(0, 1'b0, 20);
        chk("final_period", 32'(b0.O_period), 20);
        chk("final_timeout", 32'(b0.O_timeout), 0);
        b0.I_stat = 1'b0;
        repeat (10) @(negedge clk);

        chk("pending_dut0", 32'(q0.size()), 0);
        chk("pending_dut1", 32'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
